// File: rtl/vga_timing_gen.sv
// VGA pixel timing: free-running H/V counters, registered blank/sync/strobes,
// and a configurable delay line aligning hs/vs/blank_d with renderer output.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 1,
  parameter int FC_W       = 16
) (
  input  logic            vga_clk,
  input  logic            reset_n,
  output logic [9:0]      DrawX,
  output logic [9:0]      DrawY,
  output logic            blank,
  output logic            hs,
  output logic            vs,
  output logic            blank_d,
  output logic            frame_start,
  output logic            vblank_start,
  output logic [FC_W-1:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int D       = SYNC_DELAY;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_ON  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_OFF = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_ON  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] nx;
  logic [9:0] ny;
  logic       h_wrap;
  logic       n_blank;
  logic       n_hs;
  logic       n_vs;
  logic       n_fs;
  logic       n_vbs;

  // Flags are derived from the next position so they line up with DrawX/DrawY
  always_comb begin
    h_wrap = (DrawX == H_LAST);
    nx     = h_wrap ? 10'd0 : DrawX + 10'd1;
    ny     = DrawY;
    if (h_wrap)
      ny = (DrawY == V_LAST) ? 10'd0 : DrawY + 10'd1;
    n_blank = (nx < H_VIS) && (ny < V_VIS);
    n_hs    = !((nx >= HS_ON) && (nx < HS_OFF));
    n_vs    = !((ny >= VS_ON) && (ny < VS_OFF));
    n_fs    = (nx == 10'd0) && (ny == 10'd0);
    n_vbs   = (nx == 10'd0) && (ny == V_VIS);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      DrawX        <= H_LAST;
      DrawY        <= V_LAST;
      blank        <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
      frame_count  <= '0;
    end else begin
      DrawX        <= nx;
      DrawY        <= ny;
      blank        <= n_blank;
      frame_start  <= n_fs;
      vblank_start <= n_vbs;
      if (n_fs)
        frame_count <= frame_count + FC_W'(1);
    end
  end

  // Stage 0 has blank's timing; stage D is what reaches the pins
  logic [D:0] hs_pipe;
  logic [D:0] vs_pipe;
  logic [D:0] bl_pipe;

  generate
    if (D > 0) begin : g_delay
      always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
          hs_pipe <= '1;
          vs_pipe <= '1;
          bl_pipe <= '0;
        end else begin
          hs_pipe <= {hs_pipe[D-1:0], n_hs};
          vs_pipe <= {vs_pipe[D-1:0], n_vs};
          bl_pipe <= {bl_pipe[D-1:0], n_blank};
        end
      end
    end else begin : g_nodelay
      always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
          hs_pipe <= '1;
          vs_pipe <= '1;
          bl_pipe <= '0;
        end else begin
          hs_pipe <= n_hs;
          vs_pipe <= n_vs;
          bl_pipe <= n_blank;
        end
      end
    end
  endgenerate

  assign hs      = hs_pipe[D];
  assign vs      = vs_pipe[D];
  assign blank_d = bl_pipe[D];

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Pixel-timing generator for the VGA output path: free-running horizontal/vertical counters produce the `DrawX`/`DrawY`/`blank` stream consumed by the sprite renderers and palette logic. It also produces `hs`/`vs` sync pulses and a matching delayed blank for the DAC pins, delayed so they line up with the renderers' registered RGB. Frame and vblank strobes plus a frame counter drive game-logic updates (character physics, animation frame selection).

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `SYNC_DELAY`, 1, cycles of delay on `hs`/`vs`/`blank_d` relative to `DrawX`/`DrawY`/`blank` (0..4)
- `FC_W`, 16, width of `frame_count`

Ports:
- `vga_clk`  in  1  pixel clock, 25 MHz, one pixel per cycle
- `reset_n`  in  1  asynchronous, active-low reset
- `DrawX`  out  10  current horizontal counter (0..H_TOTAL-1)
- `DrawY`  out  10  current vertical counter (0..V_TOTAL-1)
- `blank`  out  1  1 = active video at (`DrawX`, `DrawY`); renderers output RGB only when 1
- `hs`  out  1  horizontal sync, active low, delayed SYNC_DELAY
- `vs`  out  1  vertical sync, active low, delayed SYNC_DELAY
- `blank_d`  out  1  `blank` delayed SYNC_DELAY
- `frame_start`  out  1  one-cycle pulse at (0,0)
- `vblank_start`  out  1  one-cycle pulse at (0,V_ACTIVE)
- `frame_count`  out  FC_W  frames started since reset, wraps

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- All outputs are registers, no combinational paths to ports. Sync/blank/strobe flags are computed from the next counter value, so they correspond to the `DrawX`/`DrawY` presented in the same cycle.
- `DrawX` increments every cycle; at H_TOTAL-1 it wraps to 0 and `DrawY` increments. `DrawY` wraps from V_TOTAL-1 to 0 on the same edge that `DrawX` wraps.
- `blank` = (`DrawX` < H_ACTIVE) and (`DrawY` < V_ACTIVE).
- Undelayed hsync is low when H_ACTIVE+H_FP ≤ `DrawX` < H_ACTIVE+H_FP+H_SYNC (656..751).
- Undelayed vsync is low for lines V_ACTIVE+V_FP ≤ `DrawY` < V_ACTIVE+V_FP+V_SYNC (490..491), for every pixel of those lines.
- `hs`, `vs`, `blank_d` pass through a SYNC_DELAY-stage shift register. SYNC_DELAY=0 gives them the same timing as `blank`.
- `frame_start` = 1 exactly when (`DrawX`,`DrawY`)=(0,0).
- `vblank_start` = 1 exactly when (`DrawX`,`DrawY`)=(0,V_ACTIVE).
- `frame_count` increments, modulo 2^FC_W, on the edge that produces `frame_start`.

## Timing
- Reset (asynchronous, `reset_n`=0) forces:
  - `DrawX`=H_TOTAL-1 (799), `DrawY`=V_TOTAL-1 (524)
  - `blank`=0, `blank_d`=0 and all delay stages 0
  - `hs`=1, `vs`=1 and all delay stages 1
  - `frame_start`=0, `vblank_start`=0, `frame_count`=0
- First rising edge after `reset_n` deasserts: (0,0), `blank`=1, `frame_start`=1, `frame_count`=1. Every frame therefore begins cleanly; no partial first frame.
- Reset asserted mid-frame takes effect immediately and is not synchronised to a frame boundary. Restart behaves exactly as from power-up.
- Line period is H_TOTAL cycles. Frame period is H_TOTAL·V_TOTAL cycles (420000). Pulses are exactly one cycle wide.
- `hs`/`vs`/`blank_d` transition exactly SYNC_DELAY cycles after the counter value that defines them.
- Counter widths: 10 bits suffice for the defaults. Parameters whose totals exceed 1024 are unsupported.

## Test plan
- Reset then release: check all reset values above. On the first edge, expect `DrawX`=0, `DrawY`=0, `blank`=1, `frame_start`=1, `frame_count`=1.
- Horizontal line (defaults, SYNC_DELAY=0):
  - `hs` low exactly 96 consecutive cycles, first low cycle at `DrawX`=656.
  - `blank` high exactly 640 cycles per visible line.
  - `DrawX` wraps 799→0 with `DrawY`+1.
- Full frame:
  - Consecutive `frame_start` pulses are 420000 cycles apart.
  - `vblank_start` occurs 384000 cycles after `frame_start`.
  - `blank` high for 307200 cycles per frame.
  - `vs` low exactly 1600 cycles, starting at (0,490).
- SYNC_DELAY=2: `hs` first low at `DrawX`=658 of the undelayed counter. `blank_d` falls 2 cycles after `blank` falls at `DrawX`=640. Lag is identical at every edge.
- Assert `reset_n` low at (300,200) for 3 cycles, then release: outputs take reset values within the same cycle, and the next frame starts at (0,0) with `frame_count`=1.
- FC_W=2: after 4 `frame_start` pulses `frame_count` reads 0, then 1 on the 5th (wrap).
